gray_window_sequencer: RTL and testbench

- Sequences the 9-pixel RGB-to-grayscale converter over a whole image stored in a synchronous RGB pixel memory.
- For every valid 3x3 window (top-left at row r, col c), it fetches 9 RGB pixels in raster order and presents them to the converter as flat registered buses.
- It waits out the converter's 1-cycle register latency, then offers the 9 grayscale results downstream with a valid/ready handshake.
- It sits between the frame memory, the converter and the downstream filter kernel.

---
 rtl/gray_window_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_gray_window_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_window_sequencer.sv
// Walks every 3x3 window of an RGB frame in pixel memory, fills the
// converter's registered input buses, and offers the nine gray results
// downstream with a valid/ready handshake.
module gray_window_sequencer #(
    parameter int BIT_PER_PIXEL = 8,
    parameter int NUM_PIXELS    = 9,
    parameter int ADDR_WIDTH    = 16,
    parameter int DIM_WIDTH     = 10
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [ADDR_WIDTH-1:0]               base_addr,
    input  logic [DIM_WIDTH-1:0]                img_width,
    input  logic [DIM_WIDTH-1:0]                img_height,
    output logic                                busy,
    output logic                                done,
    output logic                                mem_rd_en,
    output logic [ADDR_WIDTH-1:0]               mem_rd_addr,
    input  logic [3*BIT_PER_PIXEL-1:0]          mem_rd_data,
    output logic [NUM_PIXELS*BIT_PER_PIXEL-1:0] win_red,
    output logic [NUM_PIXELS*BIT_PER_PIXEL-1:0] win_green,
    output logic [NUM_PIXELS*BIT_PER_PIXEL-1:0] win_blue,
    input  logic [NUM_PIXELS*BIT_PER_PIXEL-1:0] gray_in,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [NUM_PIXELS*BIT_PER_PIXEL-1:0] out_gray,
    output logic [DIM_WIDTH-1:0]                out_row,
    output logic [DIM_WIDTH-1:0]                out_col
);

    localparam int BUS_W = NUM_PIXELS * BIT_PER_PIXEL;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WAIT  = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

    state_t                 state_r, state_s;
    logic [3:0]             k_r, k_s;           // read index within the window
    logic [1:0]             kc_r, kc_s;         // column within the current window row
    logic [DIM_WIDTH-1:0]   w_r, w_s, h_r, h_s, r_r, r_s, c_r, c_s;
    logic [ADDR_WIDTH-1:0]  row_start_r, row_start_s;   // address of pixel (r,0)
    logic [ADDR_WIDTH-1:0]  win_base_r, win_base_s;     // address of pixel (r,c)
    logic [ADDR_WIDTH-1:0]  rd_addr_r, rd_addr_s;
    logic                   rd_en_r, rd_en_s;
    logic                   done_r, done_s;
    logic                   busy_r, out_valid_r;
    logic                   cap_valid_r;
    logic [3:0]             cap_slot_r;
    logic [BUS_W-1:0]       win_red_r, win_green_r, win_blue_r;
    logic [ADDR_WIDTH-1:0]  w_ext_s;

    // Zero-extended width used for row stepping in the address path.
    assign w_ext_s = ADDR_WIDTH'(w_r);

    // Next-state, position and read-address generation.
    always_comb begin
        state_s     = state_r;
        k_s         = k_r;
        kc_s        = kc_r;
        w_s         = w_r;
        h_s         = h_r;
        r_s         = r_r;
        c_s         = c_r;
        row_start_s = row_start_r;
        win_base_s  = win_base_r;
        rd_addr_s   = rd_addr_r;
        rd_en_s     = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    w_s         = img_width;
                    h_s         = img_height;
                    r_s         = {DIM_WIDTH{1'b0}};
                    c_s         = {DIM_WIDTH{1'b0}};
                    row_start_s = base_addr;
                    win_base_s  = base_addr;
                    if ((img_width < DIM_WIDTH'(3)) || (img_height < DIM_WIDTH'(3))) begin
                        // Degenerate frame: no windows, finish immediately.
                        done_s = 1'b1;
                    end else begin
                        state_s   = ST_FETCH;
                        k_s       = 4'd0;
                        kc_s      = 2'd0;
                        rd_en_s   = 1'b1;
                        rd_addr_s = base_addr;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (k_r == 4'd8) begin
                    state_s = ST_DRAIN;
                end else begin
                    k_s     = k_r + 4'd1;
                    rd_en_s = 1'b1;
                    if (kc_r == 2'd2) begin
                        // Wrap to the first pixel of the next window row.
                        kc_s      = 2'd0;
                        rd_addr_s = rd_addr_r + w_ext_s - ADDR_WIDTH'(2);
                    end else begin
                        kc_s      = kc_r + 2'd1;
                        rd_addr_s = rd_addr_r + ADDR_WIDTH'(1);
                    end
                end
            end
            ST_DRAIN: begin
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                state_s = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    if (c_r < (w_r - DIM_WIDTH'(3))) begin
                        c_s        = c_r + DIM_WIDTH'(1);
                        win_base_s = win_base_r + ADDR_WIDTH'(1);
                        rd_addr_s  = win_base_r + ADDR_WIDTH'(1);
                        state_s    = ST_FETCH;
                        k_s        = 4'd0;
                        kc_s       = 2'd0;
                        rd_en_s    = 1'b1;
                    end else if (r_r < (h_r - DIM_WIDTH'(3))) begin
                        r_s         = r_r + DIM_WIDTH'(1);
                        c_s         = {DIM_WIDTH{1'b0}};
                        row_start_s = row_start_r + w_ext_s;
                        win_base_s  = row_start_r + w_ext_s;
                        rd_addr_s   = row_start_r + w_ext_s;
                        state_s     = ST_FETCH;
                        k_s         = 4'd0;
                        kc_s        = 2'd0;
                        rd_en_s     = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                        done_s  = 1'b1;
                    end
                end else begin
                    state_s = ST_OUT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Control state and registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            k_r         <= 4'd0;
            kc_r        <= 2'd0;
            w_r         <= {DIM_WIDTH{1'b0}};
            h_r         <= {DIM_WIDTH{1'b0}};
            r_r         <= {DIM_WIDTH{1'b0}};
            c_r         <= {DIM_WIDTH{1'b0}};
            row_start_r <= {ADDR_WIDTH{1'b0}};
            win_base_r  <= {ADDR_WIDTH{1'b0}};
            rd_addr_r   <= {ADDR_WIDTH{1'b0}};
            rd_en_r     <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
            cap_valid_r <= 1'b0;
            cap_slot_r  <= 4'd0;
        end else begin
            state_r     <= state_s;
            k_r         <= k_s;
            kc_r        <= kc_s;
            w_r         <= w_s;
            h_r         <= h_s;
            r_r         <= r_s;
            c_r         <= c_s;
            row_start_r <= row_start_s;
            win_base_r  <= win_base_s;
            rd_addr_r   <= rd_addr_s;
            rd_en_r     <= rd_en_s;
            done_r      <= done_s;
            busy_r      <= (state_s != ST_IDLE);
            out_valid_r <= (state_s == ST_OUT);
            // Memory data lands one cycle after the strobe; remember its slot.
            cap_valid_r <= rd_en_r;
            cap_slot_r  <= k_r;
        end
    end

    // Window capture: write returning pixel data into its slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_red_r   <= {BUS_W{1'b0}};
            win_green_r <= {BUS_W{1'b0}};
            win_blue_r  <= {BUS_W{1'b0}};
        end else if (cap_valid_r) begin
            win_red_r[int'(cap_slot_r)*BIT_PER_PIXEL +: BIT_PER_PIXEL]   <= mem_rd_data[3*BIT_PER_PIXEL-1 -: BIT_PER_PIXEL];
            win_green_r[int'(cap_slot_r)*BIT_PER_PIXEL +: BIT_PER_PIXEL] <= mem_rd_data[2*BIT_PER_PIXEL-1 -: BIT_PER_PIXEL];
            win_blue_r[int'(cap_slot_r)*BIT_PER_PIXEL +: BIT_PER_PIXEL]  <= mem_rd_data[BIT_PER_PIXEL-1:0];
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign mem_rd_en   = rd_en_r;
    assign mem_rd_addr = rd_addr_r;
    assign win_red     = win_red_r;
    assign win_green   = win_green_r;
    assign win_blue    = win_blue_r;
    assign out_valid   = out_valid_r;
    // The converter output is registered and held stable by win_* in OUT.
    assign out_gray    = gray_in;
    assign out_row     = r_r;
    assign out_col     = c_r;

endmodule

// File: tb/tb_gray_window_sequencer.sv
// Scoreboard bench for gray_window_sequencer: a reference model enumerates
// windows and read addresses from the frame geometry; a negedge monitor
// checks every read and every presented window against the queues.
module tb_gray_window_sequencer;

    localparam int BPP = 8;
    localparam int NP  = 9;
    localparam int AW  = 16;
    localparam int DW  = 10;
    localparam int BW  = NP * BPP;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [DW-1:0] img_width = '0;
    logic [DW-1:0] img_height = '0;
    logic          busy, done, mem_rd_en, out_valid;
    logic [AW-1:0] mem_rd_addr;
    logic [3*BPP-1:0] mem_rd_data = '0;
    logic [BW-1:0] win_red, win_green, win_blue, out_gray;
    logic [BW-1:0] gray_in = '0;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_row, out_col;

    gray_window_sequencer #(
        .BIT_PER_PIXEL(BPP), .NUM_PIXELS(NP), .ADDR_WIDTH(AW), .DIM_WIDTH(DW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .img_width(img_width), .img_height(img_height), .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .win_red(win_red), .win_green(win_green), .win_blue(win_blue),
        .gray_in(gray_in), .out_valid(out_valid), .out_ready(out_ready),
        .out_gray(out_gray), .out_row(out_row), .out_col(out_col)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pixel memory: rgb = {a, a+1, a+2} of the low address byte, 1-cycle latency.
    always @(posedge clk) begin
        if (mem_rd_en)
            mem_rd_data <= {mem_rd_addr[7:0], mem_rd_addr[7:0] + 8'd1, mem_rd_addr[7:0] + 8'd2};
    end

    // Converter stand-in: registered per-pixel channel mean.
    always @(posedge clk) begin
        for (int k = 0; k < NP; k++)
            gray_in[k*BPP +: BPP] <= 8'((10'(win_red[k*BPP +: BPP]) + 10'(win_green[k*BPP +: BPP])
                                        + 10'(win_blue[k*BPP +: BPP])) / 10'd3);
    end

    typedef struct packed {
        logic [DW-1:0] row;
        logic [DW-1:0] col;
        logic [BW-1:0] gray;
    } win_t;

    win_t          win_q[$];
    logic [AW-1:0] addr_q[$];
    int checks = 0, errors = 0;
    int exp_done = 0, done_count = 0, hs_count = 0, rd_count = 0;
    int first_rd = -1, last_rd = -1, first_valid = -1, last_hs = -1, done_cyc = -1;
    int s_cyc = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] px_gray(input logic [AW-1:0] a);
        logic [7:0] r, g, b;
        r = a[7:0];
        g = r + 8'd1;
        b = r + 8'd2;
        return 8'((int'(r) + int'(g) + int'(b)) / 3);
    endfunction

    // Reference model: every window in raster order with its nine addresses.
    task automatic push_frame(input logic [AW-1:0] base, input int w, input int h);
        win_t e;
        logic [AW-1:0] a;
        if (w >= 3 && h >= 3) begin
            for (int r = 0; r <= h - 3; r++) begin
                for (int c = 0; c <= w - 3; c++) begin
                    e.row = DW'(r);
                    e.col = DW'(c);
                    for (int k = 0; k < 9; k++) begin
                        a = AW'(int'(base) + (r + k / 3) * w + c + k % 3);
                        addr_q.push_back(a);
                        e.gray[k*BPP +: BPP] = px_gray(a);
                    end
                    win_q.push_back(e);
                end
            end
        end
        exp_done++;
    endtask

    // Monitor: compare reads, presented windows and done pulses.
    always @(negedge clk) begin : monitor
        win_t e;
        if (!reset) begin
            if (mem_rd_en) begin
                rd_count++;
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
                if (addr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_read: got addr %0h expected no read", mem_rd_addr);
                end else begin
                    check("rd_addr", mem_rd_addr, addr_q.pop_front());
                end
            end
            if (out_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (win_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_valid: got row %0d col %0d expected no window", out_row, out_col);
                end else begin
                    e = win_q[0];
                    check("out_row", out_row, e.row);
                    check("out_col", out_col, e.col);
                    check("out_gray", out_gray, e.gray);
                    if (out_ready) begin
                        void'(win_q.pop_front());
                        hs_count++;
                        last_hs = cyc;
                    end
                end
            end
            if (done) begin
                done_count++;
                done_cyc = cyc;
            end
        end
    end

    task automatic start_frame(input logic [AW-1:0] base, input int w, input int h);
        push_frame(base, w, h);
        first_rd = -1; last_rd = -1; first_valid = -1; last_hs = -1; done_cyc = -1;
        base_addr  = base;
        img_width  = DW'(w);
        img_height = DW'(h);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        s_cyc = cyc;
    endtask

    task automatic wait_frame(input string name, input bit rand_ready);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (win_q.size() == 0 && addr_q.size() == 0 && done_count == exp_done) begin
                ok = 1'b1;
                break;
            end
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got %0d windows / %0d done pending expected 0", name,
                     win_q.size(), exp_done - done_count);
        end
        repeat (3) @(posedge clk);
        #1;
        check({name, "_done_count"}, done_count, exp_done);
        check({name, "_idle"}, busy, 1'b0);
    endtask

    int hs0;

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rd_en", mem_rd_en, 1'b0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_addr", mem_rd_addr, '0);
        check("rst_win", {win_red, win_green, win_blue}, '0);
        check("rst_pos", {out_row, out_col}, '0);
        reset = 1'b0;
        @(posedge clk); #1;

        // 3x3 at 0x100: nine consecutive reads, 11-cycle latency.
        start_frame(16'h0100, 3, 3);
        wait_frame("f3x3", 1'b0);
        check("f3x3_first_rd", first_rd, s_cyc);
        check("f3x3_rd_span", last_rd - first_rd, 8);
        check("f3x3_latency", first_valid - first_rd, 11);
        check("f3x3_done_after_hs", done_cyc - last_hs, 1);

        // 4x3 with a 5-cycle stall on window 0.
        hs0 = hs_count;
        out_ready = 1'b0;
        start_frame(16'h0200, 4, 3);
        for (int i = 0; i < 40 && first_valid < 0; i++) begin
            @(posedge clk); #1;
        end
        check("f4x3_valid_seen", first_valid >= 0, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_frame("f4x3", 1'b0);
        check("f4x3_handshakes", hs_count - hs0, 2);

        // 5x4 full throughput.
        hs0 = hs_count;
        start_frame(16'h00F0, 5, 4);
        wait_frame("f5x4", 1'b0);
        check("f5x4_handshakes", hs_count - hs0, 6);
        check("f5x4_span", last_hs - first_rd + 1, 72);
        check("f5x4_done_after_hs", done_cyc - last_hs, 1);

        // Degenerate 2x5 frame: immediate done, no reads, never busy.
        rd_count = 0;
        start_frame(16'h0000, 2, 5);
        check("f2x5_busy", busy, 1'b0);
        @(posedge clk); #1;
        check("f2x5_busy_later", busy, 1'b0);
        wait_frame("f2x5", 1'b0);
        check("f2x5_done_cyc", done_cyc, s_cyc);
        check("f2x5_reads", rd_count, 0);

        // Second start while busy is ignored.
        start_frame(16'h0300, 3, 3);
        @(posedge clk); #1;
        base_addr = 16'h0000; img_width = 10'd5; img_height = 10'd5;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_frame("restart", 1'b0);

        // Reset during FETCH k=4, then a clean frame.
        start_frame(16'h0400, 3, 3);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_rd_en", mem_rd_en, 1'b0);
        check("mid_rst_addr", mem_rd_addr, '0);
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_win", {win_red, win_green, win_blue}, '0);
        check("mid_rst_pos", {out_row, out_col}, '0);
        reset = 1'b0;
        addr_q.delete();
        win_q.delete();
        exp_done = done_count;
        @(posedge clk); #1;
        start_frame(16'h0500, 3, 3);
        wait_frame("post_rst", 1'b0);

        // Randomized frames with random backpressure.
        for (int f = 0; f < 4; f++) begin
            start_frame(16'($urandom), int'($urandom_range(3, 6)), int'($urandom_range(3, 5)));
            wait_frame("rand", 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
